// File: rtl/rx_fifo_param.sv
// rx_fifo_param: parametrised single-clock FWFT receive FIFO with occupancy, thresholds, sticky errors and flush
module rx_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  always_comb begin
    pop_ok       = read_enable && count != '0;
    push_ok      = write_enable && (count != CW'(DEPTH) || pop_ok);
    fifo_empty   = count == '0;
    fifo_full    = count == CW'(DEPTH);
    almost_full  = count >= CW'(AF_LEVEL);
    almost_empty = count <= CW'(AE_LEVEL);
    read_data    = fifo_empty ? '0 : mem[rd_ptr];
  end
  // storage is deliberately left unreset; only pointers and count define validity
  always_ff @(posedge clk)
    if (push_ok && !clear) mem[wr_ptr] <= write_data;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (write_enable && !push_ok) overflow <= 1'b1;
      if (read_enable && !pop_ok) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_rx_fifo_param.sv
// tb_rx_fifo_param: directed and randomized checks of rx_fifo_param against a queue-based model
module tb_rx_fifo_param;
  localparam int DW = 8, DEPTH = 8, AF = 6, AE = 2;
  logic clk = 0, n_rst = 0, clear = 0, write_enable = 0, read_enable = 0;
  logic [DW-1:0] write_data = '0, read_data;
  logic fifo_empty, fifo_full, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int errors = 0, checks = 0;
  logic [DW-1:0] q[$];
  bit m_ov, m_un;

  rx_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .write_enable(write_enable),
    .write_data(write_data), .read_enable(read_enable), .read_data(read_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n = q.size();
    check("count", 32'(count), 32'(n));
    check("empty", 32'(fifo_empty), 32'(n == 0));
    check("full", 32'(fifo_full), 32'(n == DEPTH));
    check("almost_full", 32'(almost_full), 32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("read_data", 32'(read_data), n ? 32'(q[0]) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ov));
    check("underflow", 32'(underflow), 32'(m_un));
  endtask

  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit cl);
    bit pop, push;
    write_enable = we; write_data = wd; read_enable = re; clear = cl;
    @(posedge clk);
    if (cl) begin
      q.delete(); m_ov = 0; m_un = 0;
    end else begin
      pop  = re && q.size() > 0;
      push = we && (q.size() < DEPTH || pop);
      if (re && !pop) m_un = 1;
      if (we && !push) m_ov = 1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wd);
    end
    @(negedge clk);
    write_enable = 0; read_enable = 0; clear = 0;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 0;
    #1;
    q.delete(); m_ov = 0; m_un = 0;
    compare_all();
    @(negedge clk);
    n_rst = 1;
  endtask

  initial begin
    #2 compare_all();
    @(negedge clk) n_rst = 1;
    // 1: single write and pop
    step(1, 8'hA5, 0, 0);
    check("t1_rd", 32'(read_data), 32'hA5);
    step(0, 0, 1, 0);
    check("t1_empty", 32'(fifo_empty), 1);
    // 2: fill, overflow, drain
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
    check("t2_full", 32'(fifo_full), 1);
    step(1, 8'hFF, 0, 0);
    check("t2_ov", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain", 32'(read_data), 32'(i));
      step(0, 0, 1, 0);
    end
    // 3: full push+pop
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
    check("t3_head", 32'(read_data), 32'h01);
    step(1, 8'h55, 1, 0);
    check("t3_count", 32'(count), 8);
    check("t3_ov", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    // 4: empty push+pop
    step(1, 8'h3C, 1, 0);
    check("t4_un", 32'(underflow), 1);
    check("t4_rd", 32'(read_data), 32'h3C);
    // 5: steady occupancy with wrap
    do_reset();
    for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, 0);
    check("t5_ae3", 32'(almost_empty), 0);
    step(0, 0, 1, 0);
    check("t5_ae2", 32'(almost_empty), 1);
    // 6: clear with push, and async reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 8'h10, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h20, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check("t6_cnt5", 32'(count), 5);
    step(1, 8'h77, 0, 1);
    check("t6_clr", 32'(count), 0);
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    do_reset();
    // random
    for (int i = 0; i < 600; i++) begin
      int bias = ((i / 40) % 2) ? 75 : 30;
      step($urandom_range(0, 99) < bias, DW'($urandom),
           $urandom_range(0, 99) < 100 - bias, $urandom_range(0, 99) < 3);
      if (i % 150 == 149) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
